// File: rtl/image_sram_pkg.sv
// image_sram_pkg: shared types and helpers for the padded image store
package image_sram_pkg;

    typedef enum logic [1:0] {PAD_ZERO, PAD_REPLICATE, PAD_CONST} pad_mode_t;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    typedef enum logic [1:0] {SRC_ZERO, SRC_CONST, SRC_RAM, SRC_BYP} rd_src_t;

    function automatic int coord_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sram_model.sv
// sram_model: behavioural SRAM with optional synchronous read and separate read address
module sram_model #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 5,
    parameter int DEPTH              = 32,
    parameter int RAM_IS_SYNCHRONOUS = 1,
    parameter int DUAL               = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] ra;

    assign ra = (DUAL != 0) ? raddr : waddr;

    // storage write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (RAM_IS_SYNCHRONOUS != 0) begin : g_sync
            // registered read, holds its value when no read is requested
            always_ff @(posedge clk) begin
                if (re) rdata <= mem[ra];
            end
        end else begin : g_async
            assign rdata = mem[ra];
        end
    endgenerate

endmodule

// File: rtl/padded_image_sram.sv
// padded_image_sram: signed (x,y) image store with padding, bypass and clear sequencer
module padded_image_sram
    import image_sram_pkg::*;
#(
    parameter int                     PIXEL_DEPTH = 8,
    parameter int                     X_MAX       = 5,
    parameter int                     Y_MAX       = 5,
    parameter pad_mode_t              PAD_MODE    = PAD_ZERO,
    parameter logic [PIXEL_DEPTH-1:0] PAD_VALUE   = '0,
    parameter logic [PIXEL_DEPTH-1:0] CLEAR_VALUE = '0,
    localparam int                    XW          = coord_width(X_MAX),
    localparam int                    YW          = coord_width(Y_MAX)
) (
    input  logic                   ramclk,
    input  logic                   n_rst,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   ren,
    input  logic signed [XW-1:0]   x_addr,
    input  logic signed [YW-1:0]   y_addr,
    input  logic                   wen,
    input  logic signed [XW-1:0]   x_addr_write,
    input  logic signed [YW-1:0]   y_addr_write,
    input  logic [PIXEL_DEPTH-1:0] wdat,
    output logic [PIXEL_DEPTH-1:0] rdat,
    output logic                   rvalid,
    output logic                   roob,
    output logic                   wr_drop
);

    localparam int                   DEPTH = X_MAX * Y_MAX;
    localparam int                   AW    = $clog2(DEPTH);
    localparam logic signed [XW-1:0] X_LIM = XW'(X_MAX - 1);
    localparam logic signed [YW-1:0] Y_LIM = YW'(Y_MAX - 1);

    function automatic logic in_bounds(input logic signed [XW-1:0] x, input logic signed [YW-1:0] y);
        return !x[XW-1] && (x <= X_LIM) && !y[YW-1] && (y <= Y_LIM);
    endfunction

    // clamping is the identity for in-bounds coordinates, so one helper serves all paths
    function automatic logic [AW-1:0] lin_addr(input logic signed [XW-1:0] x, input logic signed [YW-1:0] y);
        logic signed [XW-1:0] cx;
        logic signed [YW-1:0] cy;
        cx = x[XW-1] ? '0 : (x > X_LIM) ? X_LIM : x;
        cy = y[YW-1] ? '0 : (y > Y_LIM) ? Y_LIM : y;
        return AW'($unsigned(cx)) + AW'($unsigned(cy)) * AW'(X_MAX);
    endfunction

    clr_state_t             state, state_n;
    logic [AW-1:0]          cnt, cnt_n;
    rd_src_t                src;
    logic [PIXEL_DEPTH-1:0] byp_q, ram_q, ram_wdata;
    logic [AW-1:0]          r_addr, w_addr, ram_waddr;
    logic                   rd_ok, wr_ok, r_in, w_in, byp, ram_re, ram_we;

    assign busy   = (state == CLEAR);
    assign rd_ok  = (state == IDLE) && !clear && ren;
    assign wr_ok  = (state == IDLE) && !clear && wen;
    assign r_in   = in_bounds(x_addr, y_addr);
    assign w_in   = in_bounds(x_addr_write, y_addr_write);
    assign r_addr = lin_addr(x_addr, y_addr);
    assign w_addr = lin_addr(x_addr_write, y_addr_write);
    assign byp    = rd_ok && wr_ok && r_in && w_in && (r_addr == w_addr);
    assign ram_re = rd_ok && !byp && (r_in || PAD_MODE == PAD_REPLICATE);

    // clear sequencer state and address counter
    always_ff @(posedge ramclk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next state and write-port mux between user writes and the clear walk
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ram_we    = wr_ok && w_in;
        ram_waddr = w_addr;
        ram_wdata = wdat;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = cnt;
            ram_wdata = CLEAR_VALUE;
            cnt_n     = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else if (clear) begin
            state_n = CLEAR;
        end
    end

    // read status flags and the source that rdat presents until the next accepted read
    always_ff @(posedge ramclk or negedge n_rst) begin
        if (!n_rst) begin
            rvalid  <= 1'b0;
            roob    <= 1'b0;
            wr_drop <= 1'b0;
            src     <= SRC_ZERO;
            byp_q   <= '0;
        end else begin
            rvalid  <= rd_ok;
            roob    <= rd_ok && !r_in;
            wr_drop <= wr_ok && !w_in;
            if (rd_ok) src <= byp ? SRC_BYP : ram_re ? SRC_RAM : (PAD_MODE == PAD_CONST) ? SRC_CONST : SRC_ZERO;
            if (byp) byp_q <= wdat;
        end
    end

    // output mux; SRC_ZERO after reset makes rdat read 0 without touching the SRAM
    always_comb begin
        rdat = (src == SRC_RAM) ? ram_q : (src == SRC_BYP) ? byp_q : (src == SRC_CONST) ? PAD_VALUE : '0;
    end

    sram_model #(
        .DATA_WIDTH        (PIXEL_DEPTH),
        .ADDR_WIDTH        (AW),
        .DEPTH             (DEPTH),
        .RAM_IS_SYNCHRONOUS(1),
        .DUAL              (1)
    ) u_ram (
        .clk  (ramclk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(r_addr),
        .rdata(ram_q)
    );

endmodule

// File: tb/tb_padded_image_sram.sv
// tb_padded_image_sram: randomized self-checking bench for padded_image_sram in all three pad modes
module tb_padded_image_sram;
    import image_sram_pkg::*;

    localparam logic [7:0] CLR  = 8'hC3;
    localparam logic [7:0] PADV = 8'h7F;

    logic              ramclk = 1'b0;
    logic              n_rst  = 1'b1;
    logic              clear  = 1'b0;
    logic              ren    = 1'b0;
    logic              wen    = 1'b0;
    logic signed [3:0] x_addr = '0, y_addr = '0, x_addr_write = '0, y_addr_write = '0;
    logic [7:0]        wdat   = '0;
    logic [7:0]        rdat_z, rdat_r, rdat_c;
    logic              busy_z, busy_r, busy_c;
    logic              rvalid_z, rvalid_r, rvalid_c;
    logic              roob_z, roob_r, roob_c;
    logic              wr_drop_z, wr_drop_r, wr_drop_c;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mem [25];

    always #5 ramclk = ~ramclk;

    padded_image_sram #(.PAD_MODE(PAD_ZERO), .CLEAR_VALUE(CLR)) dut_z (
        .ramclk(ramclk), .n_rst(n_rst), .clear(clear), .busy(busy_z), .ren(ren),
        .x_addr(x_addr), .y_addr(y_addr), .wen(wen), .x_addr_write(x_addr_write),
        .y_addr_write(y_addr_write), .wdat(wdat), .rdat(rdat_z), .rvalid(rvalid_z),
        .roob(roob_z), .wr_drop(wr_drop_z));

    padded_image_sram #(.PAD_MODE(PAD_REPLICATE), .CLEAR_VALUE(CLR)) dut_r (
        .ramclk(ramclk), .n_rst(n_rst), .clear(clear), .busy(busy_r), .ren(ren),
        .x_addr(x_addr), .y_addr(y_addr), .wen(wen), .x_addr_write(x_addr_write),
        .y_addr_write(y_addr_write), .wdat(wdat), .rdat(rdat_r), .rvalid(rvalid_r),
        .roob(roob_r), .wr_drop(wr_drop_r));

    padded_image_sram #(.PAD_MODE(PAD_CONST), .PAD_VALUE(PADV), .CLEAR_VALUE(CLR)) dut_c (
        .ramclk(ramclk), .n_rst(n_rst), .clear(clear), .busy(busy_c), .ren(ren),
        .x_addr(x_addr), .y_addr(y_addr), .wen(wen), .x_addr_write(x_addr_write),
        .y_addr_write(y_addr_write), .wdat(wdat), .rdat(rdat_c), .rvalid(rvalid_c),
        .roob(roob_c), .wr_drop(wr_drop_c));

    // reference model: a 5x5 image and the padding rules in plain integer arithmetic
    function automatic bit inb(input int x, input int y);
        return x >= 0 && x < 5 && y >= 0 && y < 5;
    endfunction

    function automatic logic [7:0] mrd(input int mode, input int x, input int y);
        int cx, cy;
        cx = x < 0 ? 0 : (x > 4 ? 4 : x);
        cy = y < 0 ? 0 : (y > 4 ? 4 : y);
        if (inb(x, y)) return mem[x + 5 * y];
        if (mode == 1) return mem[cx + 5 * cy];
        return mode == 2 ? PADV : 8'h00;
    endfunction

    function automatic void mwr(input int x, input int y, input logic [7:0] d);
        if (inb(x, y)) mem[x + 5 * y] = d;
    endfunction

    task automatic step(input bit r, input int x, input int y, input bit w, input int wx,
                        input int wy, input logic [7:0] d, input bit c);
        ren = r; x_addr = 4'(x); y_addr = 4'(y);
        wen = w; x_addr_write = 4'(wx); y_addr_write = 4'(wy); wdat = d;
        clear = c;
        @(posedge ramclk);
        #1;
        ren = 1'b0; wen = 1'b0; clear = 1'b0;
    endtask

    task automatic test_reset;
        #1 n_rst = 1'b0;
        #10;
        total++; if ({busy_z, busy_r, busy_c} !== 3'b0) begin bad++; $display("FAIL reset_busy got=%b want=000", {busy_z, busy_r, busy_c}); end
        total++; if ({rvalid_z, rvalid_r, rvalid_c} !== 3'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=000", {rvalid_z, rvalid_r, rvalid_c}); end
        total++; if ({roob_z, roob_r, roob_c} !== 3'b0) begin bad++; $display("FAIL reset_roob got=%b want=000", {roob_z, roob_r, roob_c}); end
        total++; if ({wr_drop_z, wr_drop_r, wr_drop_c} !== 3'b0) begin bad++; $display("FAIL reset_wr_drop got=%b want=000", {wr_drop_z, wr_drop_r, wr_drop_c}); end
        total++; if ({rdat_z, rdat_r, rdat_c} !== 24'h0) begin bad++; $display("FAIL reset_rdat got=%h want=000000", {rdat_z, rdat_r, rdat_c}); end
        @(negedge ramclk) n_rst = 1'b1;
        @(posedge ramclk); #1;
    endtask

    task automatic test_clear;
        int n;
        for (int i = 0; i < 25; i++) begin
            step(0, 0, 0, 1, i % 5, i / 5, 8'hFF, 0);
            mwr(i % 5, i / 5, 8'hFF);
        end
        step(1, 1, 1, 1, 2, 2, 8'h12, 1);
        total++; if ({busy_z, rvalid_z, wr_drop_z} !== 3'b100) begin bad++; $display("FAIL clr_start got=%b want=100 (busy,rvalid,wr_drop)", {busy_z, rvalid_z, wr_drop_z}); end
        n = 1;
        for (int k = 0; k < 40 && busy_z; k++) begin
            step(1, k % 5, (k / 5) % 5, 1, (k % 2) ? 0 : 7, 0, 8'h12, k == 5);
            total++; if ({rvalid_z, rvalid_r, rvalid_c, wr_drop_z} !== 4'b0) begin bad++; $display("FAIL clr_ignore k=%0d got=%b want=0000", k, {rvalid_z, rvalid_r, rvalid_c, wr_drop_z}); end
            if (busy_z) n++;
        end
        total++; if (n !== 25) begin bad++; $display("FAIL clr_busy_len got=%0d want=25", n); end
        total++; if ({busy_z, busy_r, busy_c} !== 3'b0) begin bad++; $display("FAIL clr_end_busy got=%b want=000", {busy_z, busy_r, busy_c}); end
        for (int i = 0; i < 25; i++) mem[i] = CLR;
        for (int i = 0; i < 25; i++) begin
            step(1, i % 5, i / 5, 0, 0, 0, 8'h00, 0);
            total++; if ({rvalid_z, roob_z, rdat_z, rdat_r, rdat_c} !== {1'b1, 1'b0, CLR, CLR, CLR}) begin bad++; $display("FAIL clr_readback i=%0d got=%b/%b/%h/%h/%h want=1/0/%h", i, rvalid_z, roob_z, rdat_z, rdat_r, rdat_c, CLR); end
        end
    endtask

    task automatic test_basic;
        step(0, 0, 0, 1, 2, 3, 8'hA5, 0); mwr(2, 3, 8'hA5);
        step(1, 2, 3, 0, 0, 0, 8'h00, 0);
        total++; if ({rvalid_z, roob_z, rdat_z} !== {1'b1, 1'b0, 8'hA5}) begin bad++; $display("FAIL basic_23 got=%b/%b/%h want=1/0/a5", rvalid_z, roob_z, rdat_z); end
        step(0, 0, 0, 0, 0, 0, 8'h00, 0);
        total++; if ({rvalid_z, roob_z, rdat_z} !== {1'b0, 1'b0, 8'hA5}) begin bad++; $display("FAIL basic_hold got=%b/%b/%h want=0/0/a5", rvalid_z, roob_z, rdat_z); end
        step(0, 0, 0, 1, 4, 4, 8'h3C, 0); mwr(4, 4, 8'h3C);
        step(1, 4, 4, 0, 0, 0, 8'h00, 0);
        total++; if ({rvalid_z, roob_z, rdat_z, rdat_c} !== {1'b1, 1'b0, 8'h3C, 8'h3C}) begin bad++; $display("FAIL basic_44 got=%b/%b/%h/%h want=1/0/3c/3c", rvalid_z, roob_z, rdat_z, rdat_c); end
    endtask

    task automatic test_padding;
        int px[5] = '{-1, 5, -2, 7, 2};
        int py[5] = '{0, 2, -1, 6, -3};
        step(0, 0, 0, 1, 0, 0, 8'h11, 0); mwr(0, 0, 8'h11);
        step(0, 0, 0, 1, 4, 4, 8'h44, 0); mwr(4, 4, 8'h44);
        step(0, 0, 0, 1, 4, 2, 8'h5B, 0); mwr(4, 2, 8'h5B);
        for (int i = 0; i < 5; i++) begin
            step(1, px[i], py[i], 0, 0, 0, 8'h00, 0);
            total++; if ({rvalid_z, roob_z, rdat_z} !== {1'b1, 1'b1, mrd(0, px[i], py[i])}) begin bad++; $display("FAIL pad_zero (%0d,%0d) got=%b/%b/%h want=1/1/%h", px[i], py[i], rvalid_z, roob_z, rdat_z, mrd(0, px[i], py[i])); end
            total++; if ({rvalid_r, roob_r, rdat_r} !== {1'b1, 1'b1, mrd(1, px[i], py[i])}) begin bad++; $display("FAIL pad_repl (%0d,%0d) got=%b/%b/%h want=1/1/%h", px[i], py[i], rvalid_r, roob_r, rdat_r, mrd(1, px[i], py[i])); end
            total++; if ({rvalid_c, roob_c, rdat_c} !== {1'b1, 1'b1, mrd(2, px[i], py[i])}) begin bad++; $display("FAIL pad_const (%0d,%0d) got=%b/%b/%h want=1/1/%h", px[i], py[i], rvalid_c, roob_c, rdat_c, mrd(2, px[i], py[i])); end
        end
    endtask

    task automatic test_write;
        step(0, 0, 0, 1, 5, 0, 8'hEE, 0);
        total++; if ({wr_drop_z, wr_drop_r, wr_drop_c} !== 3'b111) begin bad++; $display("FAIL wr_drop_pulse got=%b want=111", {wr_drop_z, wr_drop_r, wr_drop_c}); end
        step(0, 0, 0, 0, 0, 0, 8'h00, 0);
        total++; if (wr_drop_z !== 1'b0) begin bad++; $display("FAIL wr_drop_clear got=%b want=0", wr_drop_z); end
        step(0, 0, 0, 1, -1, 2, 8'hEE, 0);
        total++; if (wr_drop_z !== 1'b1) begin bad++; $display("FAIL wr_drop_neg got=%b want=1", wr_drop_z); end
        step(0, 0, 0, 1, 2, 2, 8'h2D, 0); mwr(2, 2, 8'h2D);
        total++; if (wr_drop_z !== 1'b0) begin bad++; $display("FAIL wr_drop_inb got=%b want=0", wr_drop_z); end
        for (int i = 0; i < 25; i++) begin
            step(1, i % 5, i / 5, 0, 0, 0, 8'h00, 0);
            total++; if (rdat_z !== mem[i]) begin bad++; $display("FAIL wr_unchanged i=%0d got=%h want=%h", i, rdat_z, mem[i]); end
        end
        step(1, 1, 1, 1, 1, 1, 8'h99, 0); mwr(1, 1, 8'h99);
        total++; if ({rvalid_z, rdat_z, rdat_r, rdat_c} !== {1'b1, 8'h99, 8'h99, 8'h99}) begin bad++; $display("FAIL bypass got=%b/%h/%h/%h want=1/99", rvalid_z, rdat_z, rdat_r, rdat_c); end
        step(1, 1, 1, 1, 3, 1, 8'hAB, 0); mwr(3, 1, 8'hAB);
        total++; if (rdat_z !== 8'h99) begin bad++; $display("FAIL bypass_stored got=%h want=99", rdat_z); end
    endtask

    task automatic test_random;
        logic [7:0] ez, er, ec;
        ez = 8'h00; er = 8'h00; ec = 8'h00;
        for (int k = 0; k < 300; k++) begin
            bit r, w;
            int x, y, wx, wy;
            logic [7:0] d;
            r  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            x  = int'($urandom_range(0, 10)) - 3;
            y  = int'($urandom_range(0, 10)) - 3;
            wx = (k % 7 == 0) ? x : int'($urandom_range(0, 8)) - 2;
            wy = (k % 7 == 0) ? y : int'($urandom_range(0, 8)) - 2;
            d  = 8'($urandom);
            if (r) begin
                if (w && inb(x, y) && inb(wx, wy) && x == wx && y == wy) begin
                    ez = d; er = d; ec = d;
                end else begin
                    ez = mrd(0, x, y); er = mrd(1, x, y); ec = mrd(2, x, y);
                end
            end
            if (w) mwr(wx, wy, d);
            step(r, x, y, w, wx, wy, d, 0);
            total++; if ({rvalid_z, roob_z, roob_c, wr_drop_z, rdat_z, rdat_r, rdat_c} !== {r, r && !inb(x, y), r && !inb(x, y), w && !inb(wx, wy), ez, er, ec}) begin
                bad++; $display("FAIL rand k=%0d got=%b/%b/%b/%b/%h/%h/%h want=%b/%b/%b/%h/%h/%h", k, rvalid_z, roob_z, roob_c, wr_drop_z, rdat_z, rdat_r, rdat_c, r, r && !inb(x, y), w && !inb(wx, wy), ez, er, ec);
            end
        end
    endtask

    task automatic test_streaming;
        for (int i = 0; i < 25; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            step(0, 0, 0, 1, i % 5, i / 5, d, 0);
            mwr(i % 5, i / 5, d);
        end
        for (int i = 0; i < 25; i++) begin
            step(1, i % 5, i / 5, 0, 0, 0, 8'h00, 0);
            total++; if ({rvalid_z, roob_z, rdat_z, rdat_r} !== {1'b1, 1'b0, mem[i], mem[i]}) begin bad++; $display("FAIL stream i=%0d got=%b/%b/%h/%h want=1/0/%h", i, rvalid_z, roob_z, rdat_z, rdat_r, mem[i]); end
        end
    endtask

    task automatic test_reset_midclear;
        step(0, 0, 0, 1, 0, 0, 8'h81, 0);
        step(1, 0, 0, 0, 0, 0, 8'h00, 0);
        step(0, 0, 0, 0, 0, 0, 8'h00, 1);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 8'h00, 0);
        total++; if ({busy_z, rdat_z} !== {1'b1, 8'h81}) begin bad++; $display("FAIL midclr_pre got=%b/%h want=1/81", busy_z, rdat_z); end
        #3 n_rst = 1'b0;
        #1;
        total++; if ({busy_z, rvalid_z, roob_z, wr_drop_z, rdat_z, rdat_r, rdat_c} !== 28'h0) begin bad++; $display("FAIL midclr_async got=%b/%b/%b/%b/%h/%h/%h want=all 0", busy_z, rvalid_z, roob_z, wr_drop_z, rdat_z, rdat_r, rdat_c); end
        #2 n_rst = 1'b1;
        step(0, 0, 0, 1, 3, 3, 8'h6E, 0);
        total++; if (busy_z !== 1'b0) begin bad++; $display("FAIL midclr_idle got=%b want=0", busy_z); end
        step(1, 3, 3, 0, 0, 0, 8'h00, 0);
        total++; if ({rvalid_z, roob_z, rdat_z} !== {1'b1, 1'b0, 8'h6E}) begin bad++; $display("FAIL midclr_rw got=%b/%b/%h want=1/0/6e", rvalid_z, roob_z, rdat_z); end
    endtask

    initial begin
        test_reset;
        test_clear;
        test_basic;
        test_padding;
        test_write;
        test_random;
        test_streaming;
        test_reset_midclear;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
